seq_divider16: RTL and testbench

//  Iterative unsigned integer divider: quotient = dividend / divisor, remainder = dividend % divisor.

---
 rtl/div_pkg.sv | 12 +
 rtl/lookahead_sub.sv | 56 +++++
 rtl/seq_divider16.sv | 137 +++++++++++++
 tb/tb_seq_divider16.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the iterative divider and its lookahead subtractor.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/lookahead_sub.sv
// N-bit subtractor a - b built as a + ~b + 1 with 4-bit generate/propagate groups.
// The group carries are resolved first, then each bit's carry is expanded from its group carry-in.
module lookahead_sub #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow_out
);

    localparam int NG = (N + 3) / 4;

    logic [N-1:0]  g;
    logic [N-1:0]  p;
    logic [N-1:0]  c;
    logic [NG-1:0] grp_g;
    logic [NG-1:0] grp_p;
    logic [NG:0]   gc;

    always_comb begin
        logic gg;
        logic pp;
        logic cc;
        g     = a & ~b;
        p     = a ^ ~b;
        c     = '0;
        grp_g = '0;
        grp_p = '0;
        gc    = '0;
        gc[0] = 1'b1;
        for (int k = 0; k < NG; k++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int j = 4 * k; (j < 4 * k + 4) && (j < N); j++) begin
                gg = g[j] | (p[j] & gg);
                pp = pp & p[j];
            end
            grp_g[k]  = gg;
            grp_p[k]  = pp;
            gc[k + 1] = gg | (pp & gc[k]);
        end
        // Bit carries only look back to the start of their own group.
        for (int i = 0; i < N; i++) begin
            cc = gc[i / 4];
            for (int j = (i / 4) * 4; j < i; j++) begin
                cc = g[j] | (p[j] & cc);
            end
            c[i] = cc;
        end
        diff = p ^ c;
    end

    assign borrow_out = ~gc[NG];

endmodule

// File: rtl/seq_divider16.sv
// Restoring unsigned divider producing one quotient bit per clock, valid/ready on both sides.
// A zero divisor skips the iteration and reports div_zero with an all-ones quotient.
module seq_divider16
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             unused_rem_msb;

    // The stored partial remainder is always below the divisor, so its top bit stays clear.
    assign trial          = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign unused_rem_msb = rem_q[WIDTH];

    lookahead_sub #(.N(WIDTH + 1)) u_sub (
        .a          (trial),
        .b          ({1'b0, div_q}),
        .diff       (diff),
        .borrow_out (borrow)
    );

    assign step_rem = borrow ? trial : diff;
    assign step_quo = {quo_q[WIDTH-2:0], ~borrow};

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (divisor != '0) begin
                        state_d = RUN;
                        rem_d   = '0;
                        quo_d   = dividend;
                        div_d   = divisor;
                        cnt_d   = CW'(WIDTH - 1);
                    end else begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        div_zero_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    quotient_d  = step_quo;
                    remainder_d = step_rem[WIDTH-1:0];
                    div_zero_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                // The zero-divisor path lands here with out_valid still low for one cycle.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider16.sv
// Directed vector table plus hand-written handshake, reset and randomised invariant sequences.
module tb_seq_divider16;

    logic        clk = 1'b0;
    logic        nrst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_zero;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic [15:0] dvd;
        logic [15:0] dvs;
        logic [15:0] expQuo;
        logic [15:0] expRem;
        logic        expDz;
        int          expLat;
    } vector_t;

    seq_divider16 dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    endtask

    task automatic startOp(input logic [15:0] dvd, input logic [15:0] dvs);
        int waitCycles = 0;
        while (!in_ready && waitCycles < 64) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        checkOutput("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] dvd, input logic [15:0] dvs, output int lat);
        startOp(dvd, dvs);
        waitResult(lat);
    endtask

    task automatic consumeResult();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("out_valid_cleared", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        vector_t vecs[9];
        int      lat;
        logic [31:0] prod;
        logic [15:0] rDvd, rDvs;

        vecs[0] = '{16'd100,   16'd7,      16'd14,     16'd2,    1'b0, 16};
        vecs[1] = '{16'hFFFF,  16'd1,      16'hFFFF,   16'd0,    1'b0, 16};
        vecs[2] = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,    1'b0, 16};
        vecs[3] = '{16'd3,     16'd10,     16'd0,      16'd3,    1'b0, 16};
        vecs[4] = '{16'd0,     16'd5,      16'd0,      16'd0,    1'b0, 16};
        vecs[5] = '{16'd1234,  16'd0,      16'hFFFF,   16'd1234, 1'b1, 1};
        vecs[6] = '{16'd1000,  16'd33,     16'd30,     16'd10,   1'b0, 16};
        vecs[7] = '{16'h8000,  16'h0100,   16'h0080,   16'd0,    1'b0, 16};
        vecs[8] = '{16'hFFFF,  16'd2,      16'h7FFF,   16'd1,    1'b0, 16};

        nrst      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_in_ready",  {31'd0, in_ready},  32'd1);
        checkOutput("reset_quotient",  {16'd0, quotient},  32'd0);
        checkOutput("reset_remainder", {16'd0, remainder}, 32'd0);
        checkOutput("reset_div_zero",  {31'd0, div_zero},  32'd0);
        nrst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].dvd, vecs[i].dvs, lat);
            checkOutput($sformatf("vec%0d_latency", i),   lat,                        vecs[i].expLat);
            checkOutput($sformatf("vec%0d_quotient", i),  {16'd0, quotient},          {16'd0, vecs[i].expQuo});
            checkOutput($sformatf("vec%0d_remainder", i), {16'd0, remainder},         {16'd0, vecs[i].expRem});
            checkOutput($sformatf("vec%0d_div_zero", i),  {31'd0, div_zero},          {31'd0, vecs[i].expDz});
            consumeResult();
        end

        $display("[TB] backpressure sequence");
        applyStimulus(16'd100, 16'd7, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 16'd5;
            divisor  = 16'd1;
            @(posedge clk); #1;
            checkOutput("hold_out_valid", {31'd0, out_valid},  32'd1);
            checkOutput("hold_in_ready",  {31'd0, in_ready},   32'd0);
            checkOutput("hold_quotient",  {16'd0, quotient},   32'd14);
            checkOutput("hold_remainder", {16'd0, remainder},  32'd2);
        end
        in_valid = 1'b0;
        consumeResult();
        checkOutput("idle_after_consume", {31'd0, in_ready}, 32'd1);
        applyStimulus(16'd9, 16'd4, lat);
        checkOutput("post_hold_latency",   lat,               32'd16);
        checkOutput("post_hold_quotient",  {16'd0, quotient}, 32'd2);
        checkOutput("post_hold_remainder", {16'd0, remainder}, 32'd1);
        consumeResult();

        $display("[TB] mid-operation reset sequence");
        startOp(16'd40000, 16'd3);
        repeat (7) begin
            @(posedge clk); #1;
        end
        nrst     = 1'b0;
        in_valid = 1'b1;
        dividend = 16'd5;
        divisor  = 16'd0;
        @(posedge clk); #1;
        checkOutput("midreset_in_ready",  {31'd0, in_ready},  32'd1);
        checkOutput("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midreset_quotient",  {16'd0, quotient},  32'd0);
        checkOutput("midreset_remainder", {16'd0, remainder}, 32'd0);
        checkOutput("midreset_div_zero",  {31'd0, div_zero},  32'd0);
        @(posedge clk); #1;
        checkOutput("reset_ignores_input", {31'd0, in_ready}, 32'd1);
        nrst     = 1'b1;
        in_valid = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        checkOutput("no_stale_result", {31'd0, out_valid}, 32'd0);
        applyStimulus(16'd9, 16'd4, lat);
        checkOutput("after_reset_quotient",  {16'd0, quotient},  32'd2);
        checkOutput("after_reset_remainder", {16'd0, remainder}, 32'd1);
        consumeResult();

        $display("[TB] random invariant sequence");
        for (int i = 0; i < 40; i++) begin
            rDvd = 16'($urandom);
            rDvs = (i % 2 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
            applyStimulus(rDvd, rDvs, lat);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            prod = {16'd0, quotient} * {16'd0, rDvs} + {16'd0, remainder};
            checkOutput("rand_invariant",
                        {30'd0, (prod == {16'd0, rDvd}), (remainder < rDvs)}, 32'd3);
            consumeResult();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
